// File: rtl/systolic_pkg.sv
// Shared systolic-array definitions: default geometry, the input-feeder FSM
// encoding and a saturating counter helper used by the optional perf counters.
package systolic_pkg;

   localparam int SYSTOLIC_ARRAY_WIDTH = 16;
   localparam int DATA_WIDTH_IN        = 8;
   localparam int PERF_CNT_W           = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT_W = 2'd1,
      STREAM = 2'd2,
      DRAIN  = 2'd3
   } feeder_state_t;

   // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit).
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/input_feeder_if.sv
// Input-vector handshake between the activation source (master) and the
// systolic input feeder (slave).
interface input_feeder_if #(
   parameter int N  = systolic_pkg::SYSTOLIC_ARRAY_WIDTH,
   parameter int DW = systolic_pkg::DATA_WIDTH_IN
) ();

   logic            in_valid;
   logic            in_ready;
   logic [N*DW-1:0] in_data;
   logic            in_last;

   modport master (
      output in_valid,
      output in_data,
      output in_last,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_last,
      output in_ready
   );

endinterface

// File: rtl/skew_delay_line.sv
// Fixed-depth register delay line carrying one row's {data, valid, switch}
// beat; DEPTH stages give a latency of exactly DEPTH cycles.
module skew_delay_line #(
   parameter int DEPTH = 1,
   parameter int W     = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] stage_q [DEPTH];

   // NOTE: every stage is reset, not just the output, so a reset mid-tile
   // cannot release stale valid/switch beats afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/input_feeder.sv
// Feeds input vectors into column 0 of the systolic array with a triangular
// row skew; optional perf counters are built when INPUT_FEEDER_PERF_EN is defined.
module input_feeder #(
   parameter int SYSTOLIC_ARRAY_WIDTH = systolic_pkg::SYSTOLIC_ARRAY_WIDTH,
   parameter int DATA_WIDTH_IN        = systolic_pkg::DATA_WIDTH_IN
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input_feeder_if.slave                           in_if,
   input  logic                                    w_loaded,
   output logic                                    w_consumed,
   output logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH_IN-1:0] feed_input,
   output logic [SYSTOLIC_ARRAY_WIDTH-1:0]         feed_valid,
   output logic [SYSTOLIC_ARRAY_WIDTH-1:0]         feed_switch,
   output logic                                    busy
`ifdef INPUT_FEEDER_PERF_EN
   ,
   output logic [31:0]                             beat_count,
   output logic [31:0]                             bubble_count
`endif
);

   import systolic_pkg::*;

   localparam int N     = SYSTOLIC_ARRAY_WIDTH;
   localparam int DW    = DATA_WIDTH_IN;
   localparam int BW    = DW + 2;
   localparam int CNT_W = cnt_width(N);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(N - 2);

   feeder_state_t    state_q, state_d;
   logic             head_q, head_d;
   logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
   logic             w_consumed_q;
   logic             ready;
   logic             hs;

   assign ready        = (state_q == STREAM);
   assign in_if.in_ready = ready;
   assign hs           = in_if.in_valid && ready;
   assign busy         = (state_q != IDLE);
   assign w_consumed   = w_consumed_q;

   // NOTE: every output of this block is given a default first, so no path
   // through the case can leave a variable unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      head_d      = head_q;
      drain_cnt_d = drain_cnt_q;

      case (state_q)
         IDLE: begin
            if (in_if.in_valid) state_d = WAIT_W;
         end
         WAIT_W: begin
            if (w_loaded) state_d = STREAM;
         end
         STREAM: begin
            if (hs && in_if.in_last) begin
               state_d     = (N > 1) ? DRAIN : IDLE;
               drain_cnt_d = '0;
            end
         end
         DRAIN: begin
            if (drain_cnt_q == DRAIN_LAST) begin
               state_d = in_if.in_valid ? WAIT_W : IDLE;
            end else begin
               drain_cnt_d = drain_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // The head flag re-arms whenever we are outside STREAM, so each tile's
      // first accepted beat carries the weight switch.
      if (state_q != STREAM) begin
         head_d = 1'b1;
      end else if (hs) begin
         head_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         head_q       <= 1'b1;
         drain_cnt_q  <= '0;
         w_consumed_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         head_q       <= head_d;
         drain_cnt_q  <= drain_cnt_d;
         w_consumed_q <= hs && head_q;
      end
   end

   logic [BW-1:0] row_d [N];
   logic [BW-1:0] row_q [N];

   for (genvar r = 0; r < N; r++) begin : g_row
      // A cycle without a handshake launches an all-zero bubble down the row.
      assign row_d[r] = hs ? {in_if.in_data[r*DW +: DW], 1'b1, head_q} : '0;

      skew_delay_line #(
         .DEPTH (r + 1),
         .W     (BW)
      ) u_skew (
         .clk   (clk),
         .rst_n (rst_n),
         .d_i   (row_d[r]),
         .q_o   (row_q[r])
      );

      assign feed_input[r*DW +: DW] = row_q[r][BW-1:2];
      assign feed_valid[r]          = row_q[r][1];
      assign feed_switch[r]         = row_q[r][0];
   end

`ifdef INPUT_FEEDER_PERF_EN
   logic [PERF_CNT_W-1:0] beat_count_q;
   logic [PERF_CNT_W-1:0] bubble_count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_count_q   <= '0;
         bubble_count_q <= '0;
      end else begin
         if (hs) beat_count_q <= sat_inc(beat_count_q);
         if (ready && !in_if.in_valid) bubble_count_q <= sat_inc(bubble_count_q);
      end
   end

   assign beat_count   = beat_count_q;
   assign bubble_count = bubble_count_q;
`endif

endmodule

// File: doc/input_feeder.md
INPUT_FEEDER -- requirements
Module: input_feeder

Interface
REQ-001 SHALL have parameter SYSTOLIC_ARRAY_WIDTH, default 16, number of array rows N.
REQ-002 SHALL have parameter DATA_WIDTH_IN, default 8, signed input (B) element width.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: an input vector is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the feeder accepts the vector this cycle.
REQ-007 SHALL have port in_data, input, N*DATA_WIDTH_IN bits: element r is bits [r*DATA_WIDTH_IN +: DATA_WIDTH_IN], destined for row r.
REQ-008 SHALL have port in_last, input, 1 bit: the accepted vector is the last of the tile.
REQ-009 SHALL have port w_loaded, input, 1 bit: the weight loader has filled all inactive weight registers.
REQ-010 SHALL have port w_consumed, output, 1 bit: one-cycle pulse when the tile's switch is issued on row 0.
REQ-011 SHALL have port feed_input, output, N*DATA_WIDTH_IN bits: per-row pe_input_in of column 0.
REQ-012 SHALL have port feed_valid, output, N bits: per-row pe_valid_in.
REQ-013 SHALL have port feed_switch, output, N bits: per-row pe_switch_in.
REQ-014 SHALL have port busy, output, 1 bit: high when the state is not IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, WAIT_W, STREAM and DRAIN.
REQ-016 SHALL move from IDLE to WAIT_W when in_valid is high.
REQ-017 SHALL move from WAIT_W to STREAM when w_loaded is high, and SHALL hold in_ready low in IDLE and WAIT_W.
REQ-018 SHALL drive in_ready high in STREAM, and a handshake SHALL be in_valid && in_ready.
REQ-019 SHALL mark the first handshake in STREAM as the tile head, with switch=1 for that beat only, and SHALL pulse w_consumed in the cycle its row-0 switch is driven.
REQ-020 SHALL, on a handshake with in_last=1, move to DRAIN and drop in_ready in the next cycle.
REQ-021 SHALL, for in_last=1 on the head beat, treat the tile as a single-beat tile with switch and last both applied.
REQ-022 SHALL, in DRAIN, count N-1 cycles and then go to IDLE, or to WAIT_W if in_valid is high.
REQ-023 SHALL drive row r outputs exactly r+1 cycles after the handshake, as a triangular skew: row 0 at latency 1 and row N-1 at latency N.
REQ-024 SHALL carry a per-row beat of {data element r, valid=1, switch}.
REQ-025 SHALL, in a cycle with no handshake, insert a bubble of valid=0, switch=0 and data=0 that propagates with the same skew.
REQ-026 SHALL NOT stall the skew pipeline; downstream back-pressure does not exist.
REQ-027 SHALL pass data through unmodified, with no arithmetic and no sign handling.

Reset
REQ-028 SHALL, while rst_n is low, immediately force state to IDLE, in_ready 0, w_consumed 0, busy 0, and all feed_* outputs and skew stages to 0.
REQ-029 SHALL, on reset mid-tile, discard in-flight beats, and the first tile after reset SHALL be a head (switch=1).

Configuration
REQ-030 SHALL, when INPUT_FEEDER_PERF_EN is defined, add output beat_count (32 bits) counting handshakes.
REQ-031 SHALL, when INPUT_FEEDER_PERF_EN is defined, add output bubble_count (32 bits) counting STREAM cycles without a handshake.
REQ-032 SHALL make both counters saturate at all-ones and reset to 0.
REQ-033 SHALL, when INPUT_FEEDER_PERF_EN is undefined, omit both ports and their logic.

Structure
REQ-034 SHALL take SYSTOLIC_ARRAY_WIDTH and DATA_WIDTH_IN defaults and the feeder_state_t enum from the shared package systolic_pkg.
REQ-035 SHALL implement each row delay as an instance of sub-module skew_delay_line (parameter DEPTH, payload {data, valid, switch}, async active-low reset).
REQ-036 SHALL instantiate skew_delay_line with DEPTH=r+1 for row r.

Verification (N=4)
REQ-037 SHALL cover: w_loaded=1, 3 beats 0x01020304, 0x05060708, 0x090A0B0C (last on the third) -> row0 bytes 04, 08, 0C on cycles 1-3 with switch on cycle 1 only; row3 bytes 01, 05, 09 on cycles 4-6; w_consumed pulses on cycle 1.
REQ-038 SHALL cover: in_valid high while w_loaded=0 for 5 cycles -> in_ready stays 0 and no feed_valid is asserted; w_loaded rising -> STREAM next cycle.
REQ-039 SHALL cover: in_valid low for one cycle between beats 1 and 2 -> one zero bubble per row, skewed by row index.
REQ-040 SHALL cover: a single-beat tile 0x7F80FF01 with in_last=1 -> each row gets valid=1 and switch=1 on the same beat; DRAIN lasts 3 cycles.
REQ-041 SHALL cover: rst_n pulsed low while row 2 holds a valid beat -> all feed_* outputs are 0 during reset, and the next tile head carries switch=1.
REQ-042 SHALL cover, with INPUT_FEEDER_PERF_EN defined: 3 beats plus 1 bubble -> beat_count=3, bubble_count=1.
